// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a - b - bin computed LSB first, one bit per clock.
// Optional signed-overflow output ovf is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_br;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_diff;
   logic             r_bout;
   logic             r_busy;
   logic             r_done;
   logic [1:0]       w_bit;
   logic             w_d;
   logic             w_br_next;
   logic             w_last;
`ifdef SERIAL_SUB_OVF_EN
   logic             r_ovf;
`endif

   // One-bit full subtractor, result packed as {borrow_out, difference}.
   function automatic logic [1:0] full_sub(input logic x, input logic y, input logic br);
      full_sub = {((~x & y) | (~(x ^ y) & br)), (x ^ y ^ br)};
   endfunction

   assign w_bit     = full_sub(r_a[0], r_b[0], r_br);
   assign w_d       = w_bit[0];
   assign w_br_next = w_bit[1];
   assign w_last    = (r_cnt == CW'(WIDTH - 1));

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next = S_RUN;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_RUN: begin
            if (w_last) begin
               w_next = S_DONE;
            end else begin
               w_next = S_RUN;
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // State register, operand shifters, borrow chain and result registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_br    <= 1'b0;
         r_cnt   <= '0;
         r_diff  <= '0;
         r_bout  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         r_ovf   <= 1'b0;
`endif
      end else begin
         r_state <= w_next;
         r_busy  <= (w_next == S_RUN);
         r_done  <= (w_next == S_DONE);
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a   <= a;
                  r_b   <= b;
                  r_br  <= bin;
                  r_cnt <= '0;
               end
            end
            S_RUN: begin
               r_a    <= {1'b0, r_a[WIDTH-1:1]};
               r_b    <= {1'b0, r_b[WIDTH-1:1]};
               r_br   <= w_br_next;
               r_diff <= {w_d, r_diff[WIDTH-1:1]};
               if (w_last) begin
                  r_bout <= w_br_next;
`ifdef SERIAL_SUB_OVF_EN
                  // On the final bit r_a[0]/r_b[0] are the operand sign bits.
                  r_ovf  <= (r_a[0] != r_b[0]) && (w_d != r_a[0]);
`endif
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign diff = r_diff;
   assign bout = r_bout;
`ifdef SERIAL_SUB_OVF_EN
   assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8) with an arithmetic reference model.
// Checks ovf as well when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         bout;
   logic         ovf_s;

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf   (ovf_s)
`endif
   );
`ifndef SERIAL_SUB_OVF_EN
   assign ovf_s = 1'b0;
`endif

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: plain integer arithmetic.
   function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      int unsigned t;
      t = int'(x) + 256 - int'(y) - int'(c);
      ref_diff = t[W-1:0];
   endfunction

   function automatic logic ref_bout(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      ref_bout = (int'(x) < int'(y) + int'(c));
   endfunction

   function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      logic [W-1:0] d;
      d = ref_diff(x, y, c);
      ref_ovf = (x[W-1] != y[W-1]) && (d[W-1] != x[W-1]);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issues one operation and waits for done; scrambles operands after capture.
   task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                         output logic [W-1:0] o_diff, output logic o_bout, output logic o_ovf,
                         output int busy_cycles, output bit got_done, output logic done_after);
      a = xa; b = xb; bin = xc; start = 1'b1;
      step();
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      busy_cycles = 0;
      got_done = 1'b0;
      o_diff = '0; o_bout = 1'b0; o_ovf = 1'b0; done_after = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (done) begin
            got_done = 1'b1;
            o_diff = diff; o_bout = bout; o_ovf = ovf_s;
            break;
         end
         if (busy) busy_cycles++;
         step();
      end
      if (got_done) begin
         step();
         done_after = done;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b1; a = 8'hFF; b = 8'h01; bin = 1'b1;
      step(); step();
      n_total++;
      if ({busy, done, diff, bout, ovf_s} !== 12'h000) begin
         $display("FAIL reset_outputs: got busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
                  busy, done, diff, bout, ovf_s);
      end else n_pass++;
      // start held during reset must not be accepted
      n_total++;
      if (busy !== 1'b0) $display("FAIL reset_priority: got busy=%b, want 0", busy);
      else n_pass++;
      start = 1'b0;
      rst_n = 1'b1;
      step();
   endtask

   task automatic check_op(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
      logic [W-1:0] d; logic bo, ov, da; int bc; bit gd;
      run_op(xa, xb, xc, d, bo, ov, bc, gd, da);
      n_total++;
      if (!gd) $display("FAIL %s_timeout: got no done, want done within 40 cycles", name);
      else n_pass++;
      n_total++;
      if (bc != W) $display("FAIL %s_busy_cycles: got %0d, want %0d", name, bc, W);
      else n_pass++;
      n_total++;
      if (d !== ref_diff(xa, xb, xc) || bo !== ref_bout(xa, xb, xc))
         $display("FAIL %s_result: got diff=%h bout=%b, want diff=%h bout=%b",
                  name, d, bo, ref_diff(xa, xb, xc), ref_bout(xa, xb, xc));
      else n_pass++;
`ifdef SERIAL_SUB_OVF_EN
      n_total++;
      if (ov !== ref_ovf(xa, xb, xc)) $display("FAIL %s_ovf: got %b, want %b", name, ov, ref_ovf(xa, xb, xc));
      else n_pass++;
`endif
      n_total++;
      if (da !== 1'b0) $display("FAIL %s_done_width: got done=%b one cycle later, want 0", name, da);
      else n_pass++;
      // result must hold in IDLE
      n_total++;
      if (diff !== d || bout !== bo) $display("FAIL %s_hold: got diff=%h bout=%b, want diff=%h bout=%b", name, diff, bout, d, bo);
      else n_pass++;
   endtask

   task automatic test_directed();
      check_op("dir_5a_23", 8'h5A, 8'h23, 1'b0);
      check_op("dir_10_20", 8'h10, 8'h20, 1'b1);
      check_op("dir_80_01", 8'h80, 8'h01, 1'b0);
      check_op("dir_00_00", 8'h00, 8'h00, 1'b1);
   endtask

   task automatic test_random();
      for (int k = 0; k < 25; k++) begin
         check_op("rand", W'($urandom), W'($urandom), 1'($urandom));
      end
   endtask

   task automatic test_ignored_start();
      int n_done; logic [W-1:0] d; logic bo;
      a = 8'h5A; b = 8'h23; bin = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      step(); step();
      a = 8'hFF; b = 8'h01; bin = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      n_done = 0; d = '0; bo = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if (done) begin
            n_done++;
            d = diff; bo = bout;
            a = 8'h00; b = 8'h11; bin = 1'b1; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         step();
      end
      start = 1'b0;
      n_total++;
      if (n_done != 1) $display("FAIL ignore_done_count: got %0d, want 1", n_done);
      else n_pass++;
      n_total++;
      if (d !== 8'h37 || bo !== 1'b0) $display("FAIL ignore_result: got diff=%h bout=%b, want diff=37 bout=0", d, bo);
      else n_pass++;
      n_total++;
      if (busy !== 1'b0) $display("FAIL ignore_done_start: got busy=%b, want 0", busy);
      else n_pass++;
   endtask

   task automatic test_reset_mid_run();
      int n_done;
      a = 8'hC3; b = 8'h5A; bin = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      step(); step(); step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      n_total++;
      if ({busy, done, diff, bout, ovf_s} !== 12'h000)
         $display("FAIL midrun_reset: got busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
                  busy, done, diff, bout, ovf_s);
      else n_pass++;
      n_done = 0;
      for (int i = 0; i < 15; i++) begin
         if (done || busy) n_done++;
         step();
      end
      n_total++;
      if (n_done != 0) $display("FAIL midrun_no_done: got %0d active cycles, want 0", n_done);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int t1, t2; logic [W-1:0] d1, d2; logic b1, b2;
      t1 = -1; t2 = -1; d1 = 8'hAA; d2 = 8'hAA; b1 = 1'b1; b2 = 1'b1;
      a = 8'h00; b = 8'h00; bin = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done && t1 < 0) begin
            t1 = cyc; d1 = diff; b1 = bout;
            step();
            a = 8'hFF; b = 8'hFF; bin = 1'b0; start = 1'b1;
            step();
            start = 1'b0;
         end else if (done && t1 >= 0) begin
            t2 = cyc; d2 = diff; b2 = bout;
            break;
         end else begin
            step();
         end
      end
      n_total++;
      if (t1 < 0 || t2 < 0 || (t2 - t1) != W + 2)
         $display("FAIL b2b_spacing: got t1=%0d t2=%0d, want spacing %0d", t1, t2, W + 2);
      else n_pass++;
      n_total++;
      if (d1 !== 8'h00 || b1 !== 1'b0 || d2 !== 8'h00 || b2 !== 1'b0)
         $display("FAIL b2b_results: got %h/%b and %h/%b, want 00/0 and 00/0", d1, b1, d2, b2);
      else n_pass++;
      step();
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
      test_reset();
      test_directed();
      test_ignored_start();
      test_reset_mid_run();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
